// File: rtl/disp_buf_pkg.sv
// Shared pixel types and lane helpers for the display pixel buffer.
package disp_buf_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   localparam int unsigned LANE0_LSB = 0;
   localparam int unsigned LANE1_LSB = 32;

   localparam pixel_t BLACK_PIX = 24'h000000;

   // Extract the 24-bit pixel of one lane from a 64-bit memory word.
   function automatic pixel_t lane_pixel(input logic [63:0] word, input logic lane);
      pixel_t p;
      if (lane) begin
         p = word[LANE1_LSB +: 24];
      end else begin
         p = word[LANE0_LSB +: 24];
      end
      return p;
   endfunction

endpackage

// File: rtl/disp_pix_unpack.sv
// Staging word, pixel index and lane select; requests memory pops and
// reports underflow when a pixel is requested with nothing staged.
module disp_pix_unpack
   import disp_buf_pkg::*;
#(
   parameter int unsigned PIX_PER_WORD = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        srst,
   input  logic        consume,
   input  logic        mem_empty,
   input  logic [63:0] mem_word,
   output logic        pop,
   output pixel_t      pix,
   output logic        under
);

   localparam logic LAST_IDX = (PIX_PER_WORD == 2) ? 1'b1 : 1'b0;

   logic [63:0] stg_q, stg_d;
   logic        vld_q, vld_d;
   logic        idx_q, idx_d;

   // Staging/index next state, pop request and selected pixel.
   always_comb begin
      stg_d = stg_q;
      vld_d = vld_q;
      idx_d = idx_q;
      pop   = 1'b0;
      under = 1'b0;
      pix   = BLACK_PIX;
      if (srst) begin
         stg_d = 64'h0;
         vld_d = 1'b0;
         idx_d = 1'b0;
      end else if (consume && vld_q) begin
         pix = lane_pixel(stg_q, idx_q);
         if (idx_q == LAST_IDX) begin
            idx_d = 1'b0;
            if (!mem_empty) begin
               pop   = 1'b1;
               stg_d = mem_word;
               vld_d = 1'b1;
            end else begin
               vld_d = 1'b0;
            end
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else begin
         // An empty stage always refills when memory has data; a request
         // against an empty stage is an underflow regardless.
         under = consume;
         if (!vld_q && !mem_empty) begin
            pop   = 1'b1;
            stg_d = mem_word;
            vld_d = 1'b1;
            idx_d = 1'b0;
         end else begin
            pop = 1'b0;
         end
      end
   end

   // Staging state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_q <= 64'h0;
         vld_q <= 1'b0;
         idx_q <= 1'b0;
      end else begin
         stg_q <= stg_d;
         vld_q <= vld_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/disp_pixel_fifo.sv
// Pixel buffer between the AXI read master and the timing generator.
// Optional macro DISP_PIXEL_FIFO_STICKY_EN makes BUF_OVER/BUF_UNDER sticky.
module disp_pixel_fifo
   import disp_buf_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2    = 9,
   parameter int unsigned PIX_PER_WORD  = 2,
   parameter int unsigned WREADY_MARGIN = 32
) (
   input  logic                  ACLK,
   input  logic                  ARST,
   input  logic                  FIFORST,
   input  logic                  DISPON,
   input  logic [63:0]           FIFOIN,
   input  logic                  FIFOWR,
   input  logic                  DSP_preDE,
   output logic                  BUF_WREADY,
   output logic                  BUF_OVER,
   output logic                  BUF_UNDER,
   output logic [DEPTH_LOG2:0]   BUF_LEVEL,
   output logic [7:0]            DSP_R,
   output logic [7:0]            DSP_G,
   output logic [7:0]            DSP_B,
   output logic                  DSP_DE
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

   logic [63:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] level_q, level_d;
   logic [PTR_W-1:0] level_s, free_s;
   logic             wready_q, wready_d;
   logic             over_q, over_d;
   logic             under_q, under_d;
   logic             de_q, de_d;
   pixel_t           pix_q, pix_d;
   logic             full_s, empty_s, wr_en_s, over_ev_s;
   logic             consume_s, pop_s, under_ev_s;
   logic [63:0]      mem_word_s;
   pixel_t           pix_s;

   assign level_s    = wr_ptr_q - rd_ptr_q;
   assign full_s     = (level_s == PTR_W'(DEPTH));
   assign empty_s    = (level_s == {PTR_W{1'b0}});
   assign mem_word_s = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
   assign consume_s  = DSP_preDE & DISPON;

   disp_pix_unpack #(.PIX_PER_WORD(PIX_PER_WORD)) u_unpack (
      .clk       (ACLK),
      .rst_n     (ARST),
      .srst      (FIFORST),
      .consume   (consume_s),
      .mem_empty (empty_s),
      .mem_word  (mem_word_s),
      .pop       (pop_s),
      .pix       (pix_s),
      .under     (under_ev_s)
   );

   // Pointer update, overflow detection and next values of registered outputs.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      wr_en_s   = 1'b0;
      over_ev_s = 1'b0;
      de_d      = 1'b0;
      pix_d     = BLACK_PIX;
      over_d    = 1'b0;
      under_d   = 1'b0;
      level_d   = {PTR_W{1'b0}};
      free_s    = PTR_W'(DEPTH);
      wready_d  = 1'b1;
      if (FIFORST) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
      end else begin
         // Fullness is taken before any pop this cycle.
         if (FIFOWR && full_s) begin
            over_ev_s = 1'b1;
         end else if (FIFOWR) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_en_s = 1'b0;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         de_d  = consume_s;
         pix_d = pix_s;
`ifdef DISP_PIXEL_FIFO_STICKY_EN
         over_d  = over_q | over_ev_s;
         under_d = under_q | under_ev_s;
`else
         over_d  = over_ev_s;
         under_d = under_ev_s;
`endif
         level_d  = wr_ptr_d - rd_ptr_d;
         free_s   = PTR_W'(DEPTH) - level_d;
         wready_d = (free_s >= PTR_W'(WREADY_MARGIN));
      end
   end

   // Distributed RAM write port; read is asynchronous at rd_ptr.
   always_ff @(posedge ACLK) begin
      if (wr_en_s) begin
         mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= FIFOIN;
      end
   end

   // Pointer and output registers.
   always_ff @(posedge ACLK or negedge ARST) begin
      if (!ARST) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         level_q  <= {PTR_W{1'b0}};
         wready_q <= 1'b1;
         over_q   <= 1'b0;
         under_q  <= 1'b0;
         de_q     <= 1'b0;
         pix_q    <= BLACK_PIX;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         wready_q <= wready_d;
         over_q   <= over_d;
         under_q  <= under_d;
         de_q     <= de_d;
         pix_q    <= pix_d;
      end
   end

   assign BUF_WREADY = wready_q;
   assign BUF_OVER   = over_q;
   assign BUF_UNDER  = under_q;
   assign BUF_LEVEL  = level_q;
   assign DSP_R      = pix_q.r;
   assign DSP_G      = pix_q.g;
   assign DSP_B      = pix_q.b;
   assign DSP_DE     = de_q;

endmodule

// File: tb/tb_disp_pixel_fifo.sv
// Directed bench for disp_pixel_fifo: default build (2 px/word, depth 512)
// plus a 1 px/word, depth 16 instance for streaming and pointer wrap.
module tb_disp_pixel_fifo;

   logic        clk = 1'b0;
   logic        arst;
   logic        fiforst, dispon, fifowr, prede;
   logic [63:0] fifoin;
   logic        wready, over, under, de;
   logic [9:0]  level;
   logic [7:0]  r, g, b;

   logic        fiforst1, dispon1, fifowr1, prede1;
   logic [63:0] fifoin1;
   logic        wready1, over1, under1, de1;
   logic [4:0]  level1;
   logic [7:0]  r1, g1, b1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   disp_pixel_fifo #(.DEPTH_LOG2(9), .PIX_PER_WORD(2), .WREADY_MARGIN(32)) dut (
      .ACLK(clk), .ARST(arst), .FIFORST(fiforst), .DISPON(dispon),
      .FIFOIN(fifoin), .FIFOWR(fifowr), .DSP_preDE(prede),
      .BUF_WREADY(wready), .BUF_OVER(over), .BUF_UNDER(under), .BUF_LEVEL(level),
      .DSP_R(r), .DSP_G(g), .DSP_B(b), .DSP_DE(de)
   );

   disp_pixel_fifo #(.DEPTH_LOG2(4), .PIX_PER_WORD(1), .WREADY_MARGIN(4)) dut1 (
      .ACLK(clk), .ARST(arst), .FIFORST(fiforst1), .DISPON(dispon1),
      .FIFOIN(fifoin1), .FIFOWR(fifowr1), .DSP_preDE(prede1),
      .BUF_WREADY(wready1), .BUF_OVER(over1), .BUF_UNDER(under1), .BUF_LEVEL(level1),
      .DSP_R(r1), .DSP_G(g1), .DSP_B(b1), .DSP_DE(de1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mkword(input logic [23:0] l0, input logic [23:0] l1);
      return {8'h00, l1, 8'h00, l0};
   endfunction

   logic [23:0] exp_pix;
   logic [23:0] ul0 [4];
   logic [23:0] ul1 [4];
   logic [23:0] px_exp [4];
   logic        sticky;

   initial begin
`ifdef DISP_PIXEL_FIFO_STICKY_EN
      sticky = 1'b1;
`else
      sticky = 1'b0;
`endif
      arst = 1'b0; fiforst = 1'b0; dispon = 1'b0; fifowr = 1'b0; prede = 1'b0; fifoin = 64'h0;
      fiforst1 = 1'b0; dispon1 = 1'b0; fifowr1 = 1'b0; prede1 = 1'b0; fifoin1 = 64'h0;
      tick(); tick();
      arst = 1'b1;
      tick();

      // Reset state
      check_eq("rst_level", 64'(level), 64'd0);
      check_eq("rst_wready", 64'(wready), 64'd1);
      check_eq("rst_flags", {62'd0, over, under}, 64'd0);
      check_eq("rst_de_rgb", {39'd0, de, r, g, b}, 64'd0);
      check_eq("rst_level1", 64'(level1), 64'd0);

      // Two words, four pixels
      ul0[0] = 24'h112233; ul1[0] = 24'h445566;
      ul0[1] = 24'h778899; ul1[1] = 24'hAABBCC;
      px_exp[0] = 24'h112233; px_exp[1] = 24'h445566;
      px_exp[2] = 24'h778899; px_exp[3] = 24'hAABBCC;
      fifowr = 1'b1; fifoin = mkword(ul0[0], ul1[0]);
      tick();
      check_eq("wr1_level", 64'(level), 64'd1);
      fifoin = mkword(ul0[1], ul1[1]);
      tick();
      check_eq("wr2_level", 64'(level), 64'd1);
      fifowr = 1'b0; dispon = 1'b1; prede = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("px_rgb", {40'd0, r, g, b}, 64'(px_exp[i]));
         check_eq("px_de", 64'(de), 64'd1);
         check_eq("px_under", 64'(under), 64'd0);
      end
      check_eq("px_level", 64'(level), 64'd0);
      prede = 1'b0;
      tick();
      check_eq("px_de_off", 64'(de), 64'd0);

      // Underflow on empty buffer
      prede = 1'b1;
      tick();
      check_eq("uf_de", 64'(de), 64'd1);
      check_eq("uf_rgb", {40'd0, r, g, b}, 64'd0);
      check_eq("uf_under", 64'(under), 64'd1);
      prede = 1'b0;
      tick();
      check_eq("uf_under_after", 64'(under), 64'(sticky));
      fiforst = 1'b1;
      tick();
      fiforst = 1'b0;
      check_eq("uf_clr", 64'(under), 64'd0);

      // DISPON=0 holds everything
      fifowr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fifoin = mkword(24'(i + 1), 24'(i + 9));
         tick();
      end
      fifowr = 1'b0;
      tick();
      check_eq("off_level0", 64'(level), 64'd3);
      dispon = 1'b0; prede = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("off_de_rgb", {39'd0, de, r, g, b}, 64'd0);
         check_eq("off_under", 64'(under), 64'd0);
      end
      check_eq("off_level", 64'(level), 64'd3);

      // Fill to half, then FIFORST with a write and a read in the same cycle
      prede = 1'b0; fifowr = 1'b1;
      for (int i = 0; i < 253; i++) begin
         fifoin = mkword(24'h0F0F0F, 24'h0F0F0F);
         tick();
      end
      check_eq("half_level", 64'(level), 64'd256);
      fiforst = 1'b1; dispon = 1'b1; prede = 1'b1; fifoin = mkword(24'h123456, 24'h654321);
      tick();
      check_eq("srst_level", 64'(level), 64'd0);
      check_eq("srst_flags", {62'd0, over, under}, 64'd0);
      check_eq("srst_de", 64'(de), 64'd0);
      check_eq("srst_wready", 64'(wready), 64'd1);
      fiforst = 1'b0; fifowr = 1'b0; prede = 1'b0;
      tick();
      check_eq("srst_discard", 64'(level), 64'd0);
      prede = 1'b1;
      tick();
      check_eq("srst_stg_empty", {39'd0, under, r, g, b}, 64'h1000000);
      prede = 1'b0;
      fiforst = 1'b1;
      tick();
      fiforst = 1'b0;

      // Fill past full: first word goes to staging, 512 stay in memory
      fifowr = 1'b1;
      for (int k = 1; k <= 513; k++) begin
         fifoin = mkword(24'(k - 1), 24'(k - 1) | 24'h800000);
         tick();
         if (k == 481 || k == 482 || k == 513) begin
            check_eq("fill_wready", 64'(wready), 64'(k <= 481));
         end
      end
      check_eq("full_level", 64'(level), 64'd512);
      check_eq("full_no_over", 64'(over), 64'd0);
      fifoin = mkword(24'hFFFFFF, 24'hFFFFFF);
      tick();
      check_eq("ovf_over", 64'(over), 64'd1);
      check_eq("ovf_level", 64'(level), 64'd512);
      fifowr = 1'b0;
      tick();
      check_eq("ovf_after", 64'(over), 64'(sticky));

      // Read everything back; the dropped word must not appear
      prede = 1'b1;
      for (int n = 0; n < 1026; n++) begin
         tick();
         exp_pix = ((n % 2) == 1) ? (24'(n / 2) | 24'h800000) : 24'(n / 2);
         check_eq("rb_rgb", {39'd0, de, r, g, b}, {39'd0, 1'b1, exp_pix});
      end
      check_eq("rb_no_under", 64'(under), 64'd0);
      tick();
      check_eq("rb_end_under", {39'd0, under, r, g, b}, 64'h1000000);
      check_eq("rb_end_level", 64'(level), 64'd0);
      prede = 1'b0;

      // 1 px/word streaming with pointer wrap
      dispon1 = 1'b1; fifowr1 = 1'b1;
      fifoin1 = {8'hEE, 24'hDEAD00, 8'hEE, 24'd5};
      tick();
      fifoin1 = {8'hEE, 24'hDEAD01, 8'hEE, 24'd8};
      tick();
      check_eq("p1_prime_level", 64'(level1), 64'd1);
      prede1 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         fifoin1 = {8'hEE, 24'hDEAD00 + 24'(i + 2), 8'hEE, 24'((i + 2) * 3 + 5)};
         tick();
         check_eq("p1_rgb", {39'd0, de1, r1, g1, b1}, {39'd0, 1'b1, 24'(i * 3 + 5)});
         check_eq("p1_level", 64'(level1), 64'd1);
      end
      check_eq("p1_flags", {62'd0, over1, under1}, 64'd0);
      fifowr1 = 1'b0; prede1 = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/disp_pixel_fifo.md
# disp_pixel_fifo

Parametrised single-clock pixel buffer between the display AXI read master and the timing generator. It accepts 64-bit words carrying one or two packed 24-bit RGB pixels and delivers one pixel per DSP_preDE request. Outputs are registered, aligned to a registered DSP_DE. It adds a fill-level output, a programmable write-ready margin, a DISPON gate and a black fill on underflow.

## Interface
- DEPTH_LOG2, 9, memory depth = 2^DEPTH_LOG2 64-bit words (legal 4..12)
- PIX_PER_WORD, 2, pixels per word: 1 = lane 0 only, 2 = lane 0 then lane 1
- WREADY_MARGIN, 32, free words required for BUF_WREADY=1 (1..2^DEPTH_LOG2)
- ACLK  in  1  clock for all logic
- ARST  in  1  asynchronous, active-low reset
- FIFORST  in  1  synchronous clear of contents, pointers and flags
- DISPON  in  1  display enable; 0 blocks reads and blanks output
- FIFOIN  in  64  write word: lane 0 = [23:0], lane 1 = [55:32]; [31:24] and [63:56] ignored; in each lane R=[23:16], G=[15:8], B=[7:0]
- FIFOWR  in  1  write strobe
- DSP_preDE  in  1  pixel request, one cycle ahead of DE
- BUF_WREADY  out  1  free words ≥ WREADY_MARGIN
- BUF_OVER  out  1  overflow indication
- BUF_UNDER  out  1  underflow indication
- BUF_LEVEL  out  DEPTH_LOG2+1  words held in memory (staging register excluded)
- DSP_R, DSP_G, DSP_B  out  8 each  pixel output
- DSP_DE  out  1  data enable

## Operation
- Reset (ARST=0) and FIFORST=1 give the same state: pointers, level, staging and index at 0. All outputs are 0, except BUF_WREADY, which is 1.
- FIFORST has priority over FIFOWR and reads in the same cycle. Both are ignored during FIFORST.
- Write: FIFOWR with level < 2^DEPTH_LOG2 stores the word. A write while full is dropped and flags overflow. Fullness is sampled before any same-cycle pop, so a write while full is always an overflow.
- Memory: distributed RAM with asynchronous read at rd_ptr. Pointers wrap modulo the depth. Level = wr_ptr − rd_ptr, computed with one extra bit.
- Staging: one word register plus a pixel index (0..PIX_PER_WORD−1).
  - When staging is empty and memory is non-empty, staging loads from memory (pop) with no pixel consumed.
- Consume: DSP_preDE=1 and DISPON=1.
  - Staging valid: the pixel at the current index goes to the output and the index increments.
  - On the last index, the index returns to 0. Staging reloads in the same cycle if memory is non-empty, otherwise it becomes empty.
  - Staging empty: underflow. Output is R=G=B=0 and nothing is popped.
- DISPON=0: no consume, no underflow. DSP_DE=0 and RGB=0. Writes continue.
- A write and a pop in the same cycle leave the level unchanged.

## Timing
- DSP_DE(t+1) = DSP_preDE(t) & DISPON(t). DSP_R/G/B(t+1) hold the pixel consumed at t, or 0.
- A write to an empty buffer at edge t makes level 1 after t. Staging loads at t+1. The pixel can be consumed from t+2.
- BUF_OVER and BUF_UNDER are registered and assert the cycle after the event.
- BUF_LEVEL and BUF_WREADY are registered and reflect the state after the current edge.
- Throughput:
  - PIX_PER_WORD=2: one pixel per cycle sustained from 0.5 words per cycle.
  - PIX_PER_WORD=1: one word per pixel, no bubbles while memory is non-empty.

## Configuration
- DISP_PIXEL_FIFO_STICKY_EN defined: BUF_OVER and BUF_UNDER latch at 1 until ARST or FIFORST.
- DISP_PIXEL_FIFO_STICKY_EN undefined: each flag is a 1-cycle pulse per offending cycle.

## Structure
- Package disp_buf_pkg holds:
  - pixel typedef {r, g, b} of 8 bits each
  - lane bit offsets (0, 32)
  - black pixel constant
- Sub-module disp_pix_unpack holds the staging register, pixel index, lane select and underflow detection. The top holds the memory, pointers, level, WREADY compare and output registers.

## Test plan
- Reset, then write 2 words {lane0=0x112233, lane1=0x445566}, {0x778899, 0xAABBCC}, then 4 preDE cycles with DISPON=1 -> DE=1 for 4 cycles; RGB 11/22/33, 44/55/66, 77/88/99, AA/BB/CC; BUF_UNDER=0.
- Fill 2^DEPTH_LOG2 words, then one extra write -> BUF_LEVEL=512, BUF_OVER=1 next cycle, extra word absent on readback; BUF_WREADY=0 once free <32.
- preDE on empty buffer -> DE=1, RGB=0, BUF_UNDER=1 (sticky with macro, 1-cycle pulse without).
- DISPON=0 with 4 buffered words and preDE held 10 cycles -> DE=0, RGB=0, BUF_LEVEL unchanged, no underflow.
- FIFORST in the same cycle as FIFOWR and preDE with the buffer half full -> next cycle level 0, flags 0, staging empty, write discarded.
- PIX_PER_WORD=1, continuous writes and preDE -> one pixel per cycle from lane 0 only, level stable, wrap past depth without loss.
